// File: rtl/btb_if.sv
// Fetch-lookup and resolve-update bus between the pipeline and the branch target buffer.
interface btb_if #(
  parameter int unsigned PC_W = 64
);
  logic [PC_W-1:0] lookup_pc;
  logic            pred_taken;
  logic [PC_W-1:0] pred_target;
  logic            upd_valid;
  logic [PC_W-1:0] upd_pc;
  logic            upd_taken;
  logic [PC_W-1:0] upd_target;
  logic            upd_mispredict;
  logic [31:0]     hit_count;
  logic [31:0]     mispredict_count;

  modport master (
    output lookup_pc, upd_valid, upd_pc, upd_taken, upd_target, upd_mispredict,
    input  pred_taken, pred_target, hit_count, mispredict_count
  );

  modport slave (
    input  lookup_pc, upd_valid, upd_pc, upd_taken, upd_target, upd_mispredict,
    output pred_taken, pred_target, hit_count, mispredict_count
  );
endinterface

// File: rtl/branch_target_buffer.sv
// Direct-mapped branch target buffer with 2-bit saturating direction counters
// and saturating hit / mispredict statistics.
module branch_target_buffer #(
  parameter int unsigned PC_W  = 64,
  parameter int unsigned IDX_W = 4,
  parameter int unsigned TAG_W = 8
) (
  input  logic   clk,
  input  logic   arst_n,
  input  logic   enable,
  input  logic   clear,
  btb_if.slave   bus
);
  localparam int unsigned ENTRIES = 1 << IDX_W;
  localparam int unsigned CTR_W   = 2;
  localparam int unsigned CNT_W   = 32;
  localparam int unsigned IDX_LO  = 2;
  localparam int unsigned TAG_LO  = IDX_W + 2;

  logic [ENTRIES-1:0] valid_q, valid_d;
  logic [TAG_W-1:0]   tag_q    [ENTRIES];
  logic [TAG_W-1:0]   tag_d    [ENTRIES];
  logic [PC_W-1:0]    target_q [ENTRIES];
  logic [PC_W-1:0]    target_d [ENTRIES];
  logic [CTR_W-1:0]   ctr_q    [ENTRIES];
  logic [CTR_W-1:0]   ctr_d    [ENTRIES];
  logic [CNT_W-1:0]   hit_count_q, hit_count_d;
  logic [CNT_W-1:0]   mis_count_q, mis_count_d;

  logic [IDX_W-1:0]   lk_idx, up_idx;
  logic [TAG_W-1:0]   lk_tag, up_tag;
  logic               lk_hit, up_hit;
  logic               unused_pc_bits;

  assign lk_idx = bus.lookup_pc[IDX_LO +: IDX_W];
  assign lk_tag = bus.lookup_pc[TAG_LO +: TAG_W];
  assign up_idx = bus.upd_pc[IDX_LO +: IDX_W];
  assign up_tag = bus.upd_pc[TAG_LO +: TAG_W];
  assign unused_pc_bits = ^{bus.lookup_pc, bus.upd_pc};

  // Lookup reads registered state only, so a same-cycle update is not bypassed.
  assign lk_hit = valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag);
  assign up_hit = valid_q[up_idx] && (tag_q[up_idx] == up_tag);

  assign bus.pred_taken       = lk_hit && ctr_q[lk_idx][1];
  assign bus.pred_target      = bus.pred_taken ? target_q[lk_idx] : bus.lookup_pc + PC_W'(4);
  assign bus.hit_count        = hit_count_q;
  assign bus.mispredict_count = mis_count_q;

  // Next-state: clear beats everything, then enable gates update and statistics.
  always_comb begin
    valid_d     = valid_q;
    tag_d       = tag_q;
    target_d    = target_q;
    ctr_d       = ctr_q;
    hit_count_d = hit_count_q;
    mis_count_d = mis_count_q;
    if (clear) begin
      valid_d     = '0;
      hit_count_d = '0;
      mis_count_d = '0;
      for (int unsigned i = 0; i < ENTRIES; i++) ctr_d[i] = CTR_W'(1);
    end else if (enable) begin
      if (lk_hit && (hit_count_q != '1)) hit_count_d = hit_count_q + CNT_W'(1);
      if (bus.upd_valid) begin
        if (bus.upd_mispredict && (mis_count_q != '1)) mis_count_d = mis_count_q + CNT_W'(1);
        if (up_hit) begin
          if (bus.upd_taken) begin
            if (ctr_q[up_idx] != '1) ctr_d[up_idx] = ctr_q[up_idx] + CTR_W'(1);
            target_d[up_idx] = bus.upd_target;
          end else if (ctr_q[up_idx] != '0) begin
            ctr_d[up_idx] = ctr_q[up_idx] - CTR_W'(1);
          end
        end else if (bus.upd_taken) begin
          // Allocate as weakly taken, evicting whatever shared the index.
          valid_d[up_idx]  = 1'b1;
          tag_d[up_idx]    = up_tag;
          target_d[up_idx] = bus.upd_target;
          ctr_d[up_idx]    = CTR_W'(2);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      valid_q     <= '0;
      hit_count_q <= '0;
      mis_count_q <= '0;
      for (int unsigned i = 0; i < ENTRIES; i++) begin
        tag_q[i]    <= '0;
        target_q[i] <= '0;
        ctr_q[i]    <= CTR_W'(1);
      end
    end else begin
      valid_q     <= valid_d;
      tag_q       <= tag_d;
      target_q    <= target_d;
      ctr_q       <= ctr_d;
      hit_count_q <= hit_count_d;
      mis_count_q <= mis_count_d;
    end
  end
endmodule

// File: tb/tb_branch_target_buffer.sv
// Directed bench for branch_target_buffer: allocation, counters, replacement,
// statistics, clear and asynchronous reset.
module tb_branch_target_buffer;
  logic clk;
  logic arst_n;
  logic enable;
  logic clear;
  int   n_vec;
  int   n_err;

  btb_if #(.PC_W(64)) bus ();

  branch_target_buffer #(.PC_W(64), .IDX_W(4), .TAG_W(8)) u_dut (
    .clk    (clk),
    .arst_n (arst_n),
    .enable (enable),
    .clear  (clear),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic do_update(input logic [63:0] pc, input logic tk, input logic [63:0] tgt, input logic mis);
    @(negedge clk);
    bus.upd_valid = 1'b1; bus.upd_pc = pc; bus.upd_taken = tk;
    bus.upd_target = tgt; bus.upd_mispredict = mis;
    @(posedge clk); #1;
    bus.upd_valid = 1'b0; bus.upd_mispredict = 1'b0;
  endtask

  task automatic test_reset();
    arst_n = 1'b0; enable = 1'b0; clear = 1'b0;
    bus.upd_valid = 1'b0; bus.upd_pc = '0; bus.upd_taken = 1'b0;
    bus.upd_target = '0; bus.upd_mispredict = 1'b0;
    bus.lookup_pc = 64'h100;
    #1;
    n_vec++; if (bus.pred_taken !== 1'b0) begin n_err++; $display("FAIL reset_pred_taken: got %b want 0", bus.pred_taken); end
    n_vec++; if (bus.pred_target !== 64'h104) begin n_err++; $display("FAIL reset_pred_target: got %h want 104", bus.pred_target); end
    n_vec++; if (bus.hit_count !== 32'd0) begin n_err++; $display("FAIL reset_hit_count: got %0d want 0", bus.hit_count); end
    n_vec++; if (bus.mispredict_count !== 32'd0) begin n_err++; $display("FAIL reset_mis_count: got %0d want 0", bus.mispredict_count); end
    bus.lookup_pc = 64'hFFFF_FFFF_FFFF_FFFC; #1;
    n_vec++; if (bus.pred_target !== 64'h0) begin n_err++; $display("FAIL pc_wrap_target: got %h want 0", bus.pred_target); end
    repeat (2) @(posedge clk);
    @(negedge clk);
    arst_n = 1'b1; enable = 1'b1; bus.lookup_pc = 64'h100;
  endtask

  task automatic test_allocate();
    @(negedge clk);
    bus.upd_valid = 1'b1; bus.upd_pc = 64'h100; bus.upd_taken = 1'b1; bus.upd_target = 64'h80;
    #1;
    n_vec++; if (bus.pred_taken !== 1'b0) begin n_err++; $display("FAIL no_bypass_taken: got %b want 0", bus.pred_taken); end
    n_vec++; if (bus.pred_target !== 64'h104) begin n_err++; $display("FAIL no_bypass_target: got %h want 104", bus.pred_target); end
    @(posedge clk); #1;
    bus.upd_valid = 1'b0;
    n_vec++; if (bus.pred_taken !== 1'b1) begin n_err++; $display("FAIL alloc_taken: got %b want 1", bus.pred_taken); end
    n_vec++; if (bus.pred_target !== 64'h80) begin n_err++; $display("FAIL alloc_target: got %h want 80", bus.pred_target); end
    n_vec++; if (bus.hit_count !== 32'd0) begin n_err++; $display("FAIL alloc_hits0: got %0d want 0", bus.hit_count); end
    @(posedge clk); #1;
    n_vec++; if (bus.hit_count !== 32'd1) begin n_err++; $display("FAIL hits_1: got %0d want 1", bus.hit_count); end
    @(posedge clk); #1;
    n_vec++; if (bus.hit_count !== 32'd2) begin n_err++; $display("FAIL hits_2: got %0d want 2", bus.hit_count); end
    enable = 1'b0;
    @(posedge clk); #1;
    n_vec++; if (bus.hit_count !== 32'd2) begin n_err++; $display("FAIL hits_hold_disabled: got %0d want 2", bus.hit_count); end
    enable = 1'b1;
  endtask

  task automatic test_counter();
    bus.lookup_pc = 64'h100;
    do_update(64'h100, 1'b0, 64'h0, 1'b0);
    n_vec++; if (bus.pred_taken !== 1'b0) begin n_err++; $display("FAIL ctr_2to1_taken: got %b want 0", bus.pred_taken); end
    n_vec++; if (bus.pred_target !== 64'h104) begin n_err++; $display("FAIL ctr_2to1_target: got %h want 104", bus.pred_target); end
    do_update(64'h100, 1'b0, 64'h0, 1'b0);
    do_update(64'h100, 1'b0, 64'h0, 1'b0);
    n_vec++; if (bus.pred_taken !== 1'b0) begin n_err++; $display("FAIL ctr_floor_taken: got %b want 0", bus.pred_taken); end
    do_update(64'h100, 1'b1, 64'h90, 1'b0);
    n_vec++; if (bus.pred_taken !== 1'b0) begin n_err++; $display("FAIL ctr_0to1_taken: got %b want 0", bus.pred_taken); end
    n_vec++; if (bus.pred_target !== 64'h104) begin n_err++; $display("FAIL ctr_0to1_target: got %h want 104", bus.pred_target); end
    do_update(64'h100, 1'b1, 64'h90, 1'b0);
    n_vec++; if (bus.pred_target !== 64'h90) begin n_err++; $display("FAIL ctr_1to2_target: got %h want 90", bus.pred_target); end
    do_update(64'h100, 1'b1, 64'h90, 1'b0);
    do_update(64'h100, 1'b1, 64'h90, 1'b0);
    n_vec++; if (bus.pred_taken !== 1'b1) begin n_err++; $display("FAIL ctr_sat3_taken: got %b want 1", bus.pred_taken); end
    do_update(64'h100, 1'b0, 64'h0, 1'b0);
    n_vec++; if (bus.pred_taken !== 1'b1) begin n_err++; $display("FAIL ctr_3to2_taken: got %b want 1", bus.pred_taken); end
    do_update(64'h100, 1'b0, 64'h0, 1'b0);
    n_vec++; if (bus.pred_taken !== 1'b0) begin n_err++; $display("FAIL ctr_2to1b_taken: got %b want 0", bus.pred_taken); end
    do_update(64'h100, 1'b1, 64'h80, 1'b0);
    n_vec++; if (bus.pred_target !== 64'h80) begin n_err++; $display("FAIL ctr_retarget: got %h want 80", bus.pred_target); end
  endtask

  task automatic test_replace();
    bus.lookup_pc = 64'h140; #1;
    n_vec++; if (bus.pred_taken !== 1'b0) begin n_err++; $display("FAIL tag_miss_taken: got %b want 0", bus.pred_taken); end
    n_vec++; if (bus.pred_target !== 64'h144) begin n_err++; $display("FAIL tag_miss_target: got %h want 144", bus.pred_target); end
    do_update(64'h140, 1'b1, 64'hA0, 1'b0);
    n_vec++; if (bus.pred_target !== 64'hA0) begin n_err++; $display("FAIL replace_target: got %h want a0", bus.pred_target); end
    bus.lookup_pc = 64'h141; #1;
    n_vec++; if (bus.pred_target !== 64'hA0) begin n_err++; $display("FAIL alias_target: got %h want a0", bus.pred_target); end
    bus.lookup_pc = 64'h100; #1;
    n_vec++; if (bus.pred_taken !== 1'b0) begin n_err++; $display("FAIL evicted_taken: got %b want 0", bus.pred_taken); end
    do_update(64'h200, 1'b0, 64'h55, 1'b0);
    bus.lookup_pc = 64'h140; #1;
    n_vec++; if (bus.pred_target !== 64'hA0) begin n_err++; $display("FAIL nt_miss_nochange: got %h want a0", bus.pred_target); end
    bus.lookup_pc = 64'h200; #1;
    n_vec++; if (bus.pred_taken !== 1'b0) begin n_err++; $display("FAIL nt_miss_noalloc: got %b want 0", bus.pred_taken); end
  endtask

  task automatic test_mispredict();
    bus.lookup_pc = 64'h140; #1;
    n_vec++; if (bus.mispredict_count !== 32'd0) begin n_err++; $display("FAIL mis_start: got %0d want 0", bus.mispredict_count); end
    enable = 1'b0;
    do_update(64'h140, 1'b0, 64'h0, 1'b1);
    n_vec++; if (bus.pred_taken !== 1'b1) begin n_err++; $display("FAIL disabled_table_hold: got %b want 1", bus.pred_taken); end
    n_vec++; if (bus.mispredict_count !== 32'd0) begin n_err++; $display("FAIL disabled_mis_hold: got %0d want 0", bus.mispredict_count); end
    enable = 1'b1;
    do_update(64'h140, 1'b1, 64'hA0, 1'b1);
    n_vec++; if (bus.mispredict_count !== 32'd1) begin n_err++; $display("FAIL mis_count_1: got %0d want 1", bus.mispredict_count); end
    @(negedge clk);
    bus.upd_valid = 1'b0; bus.upd_mispredict = 1'b1;
    @(posedge clk); #1;
    bus.upd_mispredict = 1'b0;
    n_vec++; if (bus.mispredict_count !== 32'd1) begin n_err++; $display("FAIL mis_without_valid: got %0d want 1", bus.mispredict_count); end
  endtask

  task automatic test_clear();
    @(negedge clk);
    clear = 1'b1; enable = 1'b0;
    bus.upd_valid = 1'b1; bus.upd_pc = 64'h300; bus.upd_taken = 1'b1; bus.upd_target = 64'hC0;
    @(posedge clk); #1;
    clear = 1'b0; enable = 1'b1; bus.upd_valid = 1'b0;
    bus.lookup_pc = 64'h140; #1;
    n_vec++; if (bus.pred_taken !== 1'b0) begin n_err++; $display("FAIL clear_miss: got %b want 0", bus.pred_taken); end
    n_vec++; if (bus.hit_count !== 32'd0) begin n_err++; $display("FAIL clear_hits: got %0d want 0", bus.hit_count); end
    n_vec++; if (bus.mispredict_count !== 32'd0) begin n_err++; $display("FAIL clear_mis: got %0d want 0", bus.mispredict_count); end
    bus.lookup_pc = 64'h300; #1;
    n_vec++; if (bus.pred_taken !== 1'b0) begin n_err++; $display("FAIL clear_beats_update: got %b want 0", bus.pred_taken); end
    bus.lookup_pc = 64'h100;
    do_update(64'h100, 1'b1, 64'h80, 1'b0);
    n_vec++; if (bus.pred_target !== 64'h80) begin n_err++; $display("FAIL post_clear_alloc: got %h want 80", bus.pred_target); end
    n_vec++; if (bus.hit_count !== 32'd0) begin n_err++; $display("FAIL post_clear_hits0: got %0d want 0", bus.hit_count); end
    @(posedge clk); #1;
    n_vec++; if (bus.hit_count !== 32'd1) begin n_err++; $display("FAIL post_clear_hits1: got %0d want 1", bus.hit_count); end
  endtask

  task automatic test_back_to_back();
    @(negedge clk);
    bus.upd_valid = 1'b1; bus.upd_pc = 64'h104; bus.upd_taken = 1'b1; bus.upd_target = 64'h1110;
    @(negedge clk);
    bus.upd_pc = 64'h108; bus.upd_target = 64'h2220;
    @(negedge clk);
    bus.upd_valid = 1'b0;
    bus.lookup_pc = 64'h104; #1;
    n_vec++; if (bus.pred_target !== 64'h1110) begin n_err++; $display("FAIL b2b_first: got %h want 1110", bus.pred_target); end
    bus.lookup_pc = 64'h108; #1;
    n_vec++; if (bus.pred_target !== 64'h2220) begin n_err++; $display("FAIL b2b_second: got %h want 2220", bus.pred_target); end
  endtask

  task automatic test_async_reset();
    bus.lookup_pc = 64'h100;
    @(negedge clk);
    bus.upd_valid = 1'b1; bus.upd_pc = 64'h140; bus.upd_taken = 1'b1;
    bus.upd_target = 64'hA0; bus.upd_mispredict = 1'b1;
    #2 arst_n = 1'b0;
    #1;
    n_vec++; if (bus.pred_taken !== 1'b0) begin n_err++; $display("FAIL arst_taken: got %b want 0", bus.pred_taken); end
    n_vec++; if (bus.pred_target !== 64'h104) begin n_err++; $display("FAIL arst_target: got %h want 104", bus.pred_target); end
    n_vec++; if (bus.hit_count !== 32'd0) begin n_err++; $display("FAIL arst_hits: got %0d want 0", bus.hit_count); end
    @(posedge clk);
    @(negedge clk);
    arst_n = 1'b1; bus.upd_valid = 1'b0; bus.upd_mispredict = 1'b0;
    bus.lookup_pc = 64'h140;
    @(posedge clk); #1;
    n_vec++; if (bus.pred_taken !== 1'b0) begin n_err++; $display("FAIL arst_update_lost: got %b want 0", bus.pred_taken); end
    n_vec++; if (bus.mispredict_count !== 32'd0) begin n_err++; $display("FAIL arst_mis_lost: got %0d want 0", bus.mispredict_count); end
    do_update(64'h140, 1'b0, 64'h44, 1'b0);
    n_vec++; if (bus.pred_taken !== 1'b0) begin n_err++; $display("FAIL arst_nt_empty: got %b want 0", bus.pred_taken); end
    do_update(64'h140, 1'b1, 64'hB0, 1'b0);
    n_vec++; if (bus.pred_target !== 64'hB0) begin n_err++; $display("FAIL arst_first_alloc: got %h want b0", bus.pred_target); end
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    test_reset();
    test_allocate();
    test_counter();
    test_replace();
    test_mispredict();
    test_clear();
    test_back_to_back();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/branch_target_buffer.md
BRANCH_TARGET_BUFFER -- requirements
Module: branch_target_buffer

Interface
REQ-001 Parameter PC_W, default 64: width of program-counter and target buses.
REQ-002 Parameter IDX_W, default 4: index width; the table SHALL hold 2**IDX_W entries.
REQ-003 Parameter TAG_W, default 8: stored tag width; IDX_W+TAG_W+2 SHALL be <= PC_W.
REQ-004 clk  in  1  single clock; all state SHALL update on the rising edge.
REQ-005 arst_n  in  1  reset, asynchronous, active-low.
REQ-006 enable  in  1  pipeline advance; when low, table and statistics SHALL hold.
REQ-007 clear  in  1  synchronous invalidate of all entries and statistics.
REQ-008 lookup_pc  in  PC_W  IF-stage fetch PC.
REQ-009 pred_taken  out  1  predict taken for lookup_pc.
REQ-010 pred_target  out  PC_W  next fetch PC predicted for lookup_pc.
REQ-011 upd_valid  in  1  ID-stage resolved conditional branch present.
REQ-012 upd_pc  in  PC_W  PC of the resolved branch.
REQ-013 upd_taken  in  1  actual branch outcome.
REQ-014 upd_target  in  PC_W  actual branch target.
REQ-015 upd_mispredict  in  1  ID stage flagged this branch as mispredicted (flush issued).
REQ-016 hit_count  out  32  number of enabled cycles with a lookup hit.
REQ-017 mispredict_count  out  32  number of enabled mispredicted updates.

Function
REQ-018 Index SHALL be pc[IDX_W+1:2]; tag SHALL be pc[IDX_W+TAG_W+1:IDX_W+2].
REQ-019 Each entry SHALL hold valid bit, TAG_W tag, PC_W target, 2-bit saturating counter.
REQ-020 Lookup hit SHALL be: entry at index valid and stored tag equals lookup tag.
REQ-021 pred_taken SHALL be combinational: hit AND counter[1].
REQ-022 pred_target SHALL equal stored target when pred_taken, else lookup_pc+4 (modulo 2**PC_W).
REQ-023 Update SHALL occur only when enable AND upd_valid AND NOT clear; effect visible the cycle after.
REQ-024 Update on hit: counter increments if upd_taken (saturate at 3), decrements otherwise (saturate at 0); target overwritten with upd_target only if upd_taken.
REQ-025 Update on miss with upd_taken=1: allocate/replace entry: valid=1, new tag, target=upd_target, counter=2 (weakly taken).
REQ-026 Update on miss with upd_taken=0: no table change.
REQ-027 Lookup and update to the same index in one cycle: lookup SHALL see pre-update contents (no bypass).
REQ-028 Aliasing entries (same index and tag, different PC) SHALL share state; no detection.
REQ-029 hit_count SHALL increment on each rising edge with enable=1, clear=0 and lookup hit; saturate at 32'hFFFF_FFFF.
REQ-030 mispredict_count SHALL increment when enable AND upd_valid AND upd_mispredict AND NOT clear; saturate at 32'hFFFF_FFFF.
REQ-031 clear=1 SHALL, regardless of enable, zero all valid bits, set all counters to 1, zero both statistics; clear has priority over update.
REQ-032 upd_mispredict with upd_valid=0 SHALL be ignored.

Reset
REQ-033 On arst_n low, immediately and independent of clk: all valid=0, all counters=1 (weakly not-taken), targets=0, hit_count=0, mispredict_count=0.
REQ-034 During reset pred_taken SHALL be 0 and pred_target SHALL be lookup_pc+4.
REQ-035 Reset asserted mid-update SHALL discard that update; first update after release SHALL behave as on an empty table.

Verification
REQ-036 Reset, lookup_pc=0x100 -> pred_taken=0, pred_target=0x104, hit_count=0.
REQ-037 Update upd_pc=0x100, taken=1, target=0x80; next cycle lookup 0x100 -> pred_taken=1, pred_target=0x80, hit_count increments by 1 per enabled cycle.
REQ-038 Same entry, two not-taken updates -> counter 2->1->0, lookup 0x100 gives pred_taken=0, pred_target=0x104; three taken updates -> counter 3, stays 3 on fourth.
REQ-039 Lookup 0x140 (same index as 0x100 at IDX_W=4, different tag) after 0x100 allocated -> miss, pred_taken=0; taken update at 0x140 replaces entry, 0x100 then misses.
REQ-040 enable=0 with upd_valid=1, upd_mispredict=1 -> no table or counter change; enable=1 -> mispredict_count=1; clear pulse -> all lookups miss, both statistics 0.
REQ-041 arst_n pulsed low between clock edges with valid entries -> outputs reset immediately; same-cycle upd_valid lost.
